// File: rtl/button_debounce_pkg.sv
// Shared constants for the input-conditioning blocks: debounce FSM state
// encoding and the default stability window (10 ms at 100 MHz).
package button_debounce_pkg;

    localparam logic [1:0] IDLE_LOW  = 2'b00;
    localparam logic [1:0] WAIT_HIGH = 2'b01;
    localparam logic [1:0] IDLE_HIGH = 2'b11;
    localparam logic [1:0] WAIT_LOW  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE_LOW  = IDLE_LOW,
        ST_WAIT_HIGH = WAIT_HIGH,
        ST_IDLE_HIGH = IDLE_HIGH,
        ST_WAIT_LOW  = WAIT_LOW
    } state_e;

    localparam int DEFAULT_STABLE_CYCLES = 1000000;

endpackage

// File: rtl/button_debounce_sync.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
// Ports: clk, reset_n (async active-low), d (async in), q (synchronized out).
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// button_debounce: filters contact bounce on a raw button/switch level.
// Ports: clk, reset_n (async active-low), D_in (raw level), D_out
// (debounced, registered), busy (candidate change being qualified).
// Macro DEBOUNCE_SYNC_EN: when defined, D_in passes a 2-flop synchronizer.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic D_in,
    output logic D_out,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic samp;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (D_in),
        .q       (samp)
    );
`else
    assign samp = D_in;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_out_q, d_out_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_out_d = d_out_q;
        unique case (state_q)
            ST_IDLE_LOW: begin
                if (samp) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_WAIT_HIGH: begin
                // Any low sample drops the candidate; no partial credit.
                if (!samp) begin
                    state_d = ST_IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE_HIGH;
                    d_out_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_IDLE_HIGH: begin
                if (!samp) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (samp) begin
                    state_d = ST_IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE_LOW;
                    d_out_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE_LOW;
                cnt_d   = '0;
                d_out_d = 1'b0;
            end
        endcase
        // busy tracks the state being entered so it aligns with it.
        busy_d = (state_d == ST_WAIT_HIGH) || (state_d == ST_WAIT_LOW);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE_LOW;
            cnt_q   <= '0;
            d_out_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_out_q <= d_out_d;
            busy_q  <= busy_d;
        end
    end

    assign D_out = d_out_q;
    assign busy  = busy_q;

endmodule
